instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage of the RISC-V core, directly upstream of instruction decode and the control unit. Owns the fetch PC, issues word requests to instruction memory over a request/grant/response handshake and buffers returned instructions in a small in-order queue. Presents one instruction per valid/ready handshake to decode, whose `instr[6:0]` drives the control unit's opcode input. Branch/jump resolution from execute redirects it through `redirect`/`redirect_pc`.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: instruction queue entries; legal range 2..8.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: word address of the request; always equal to fetch_pc.
- `imem_gnt` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response data valid; responses return in order.
- `imem_rdata` in 32: instruction word.
- `redirect` in 1: flush and restart fetch (taken branch, jal).
- `redirect_pc` in 32: new fetch address; bits [1:0] ignored and forced to 0.
- `instr_valid` out 1: queue head valid.
- `instr` out 32: queue head instruction.
- `instr_pc` out 32: PC of the queue head.
- `instr_pc_plus4` out 32: `instr_pc + 4`, modulo 2^32.
- `instr_ready` in 1: decode consumes the head.

## Operation
- Registered state: fetch_pc (32), FSM state, queue (DEPTH x {instr, pc}) with read/write pointers and count.
- At most one memory request is outstanding at any time.
- FSM states:
  - REQ: no request outstanding. `imem_req = (count < DEPTH) && !redirect`. On `imem_req && imem_gnt`, fetch_pc += 4 and move to WAIT.
  - WAIT: one request outstanding, response kept. On `imem_rvalid`, push {`imem_rdata`, fetch_pc-4} and move to REQ.
  - DROP: one request outstanding, response discarded. On `imem_rvalid`, discard the data and move to REQ.
- Redirect has priority over every other event in the same cycle:
  - Queue flushes: count=0, pointers reset, any simultaneous pop or push is dropped.
  - fetch_pc is set to `{redirect_pc[31:2], 2'b00}`.
  - REQ: request suppressed this cycle; stay in REQ.
  - WAIT without `imem_rvalid`: go to DROP.
  - WAIT with `imem_rvalid`: data discarded; go to REQ.
  - DROP: fetch_pc updated; stay in DROP, or go to REQ if `imem_rvalid`.
- Pop happens when `instr_valid && instr_ready && !redirect`. Push and pop may occur in the same cycle, and count is then unchanged.
- A push into a full queue cannot occur, because requests are only issued when count < DEPTH.
- Empty queue: `instr`, `instr_pc` and `instr_pc_plus4` are 32'h0. Decode therefore sees opcode 0 and the control unit outputs its all-zero default.
- PC arithmetic wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - state REQ, fetch_pc = `RESET_PC`, count 0.
  - `imem_req`=0 (gated by rst_n), `imem_addr`=`RESET_PC`.
  - `instr_valid`=0, `instr`/`instr_pc`/`instr_pc_plus4`=0.
- First request: `imem_req`=1 in the first cycle after rst_n rises.
- `imem_req` is combinational from state, count and `redirect`. `imem_addr` is registered.
- Latency: response captured at edge N makes `instr_valid`=1 in cycle N+1.
- Best case with gnt and rvalid each taking 1 cycle: one instruction every 2 cycles.
- Reset asserted mid-operation: all state returns to reset values immediately. A memory response already in flight when rst_n deasserts is the memory's responsibility and must not arrive.
- `imem_rvalid` in REQ is a protocol error; it is ignored and never pushed.

## Test plan
- Reset, then memory returns 32'h0000_0093 for address 0 with gnt=1 and rvalid one cycle later → `imem_addr`=0; `instr_valid`=1, `instr`=32'h0000_0093, `instr_pc`=0, `instr_pc_plus4`=4.
- Streaming, DEPTH=2, `instr_ready`=0 → exactly 2 instructions queued (PCs 0 and 4), `imem_req` stays 0 and `imem_addr`=8. `instr_ready`=1 → PCs popped in order 0, 4, then 8.
- Redirect in WAIT before rvalid, `redirect_pc`=32'h0000_0102 → state DROP. The next rvalid data never appears at `instr`. The next `imem_addr`=32'h0000_0100 and queue count=0.
- Redirect in the same cycle as rvalid and a pop, queue holding 1 entry → queue empty next cycle, returned word discarded, next request at the redirect address.
- fetch_pc=32'hFFFF_FFFC, fetch granted → instruction has `instr_pc`=32'hFFFF_FFFC and `instr_pc_plus4`=0; next `imem_addr`=0.
- rst_n pulsed low while in WAIT with 1 queued entry → same cycle: `instr_valid`=0, `imem_req`=0. After release: `imem_addr`=`RESET_PC`, and fetch restarts from `RESET_PC`.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RISC-V instruction fetch: PC, single-outstanding imem handshake, in-order queue
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  input  logic        instr_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t          state, state_nxt;
  logic [31:0]     fetch_pc;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     q_instr [DEPTH];
  logic [31:0]     q_pc    [DEPTH];
  logic            push, pop, granted;

  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign push        = (state == S_WAIT) && imem_rvalid && !redirect;
  assign pop         = instr_valid && instr_ready && !redirect;
  assign granted     = imem_req && imem_gnt;

  // Request only when idle, with queue room, and not being redirected.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      S_REQ: begin
        imem_req = rst_n && (count < CW'(DEPTH)) && !redirect;
        if (imem_req && imem_gnt) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)   state_nxt = S_REQ;
        else if (redirect) state_nxt = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (granted) fetch_pc <= fetch_pc + 32'd4;
        if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  // fetch_pc already advanced at grant, so the response belongs to fetch_pc-4.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= fetch_pc - 32'd4;
    end
  end

  assign instr          = instr_valid ? q_instr[rd_ptr] : 32'h0;
  assign instr_pc       = instr_valid ? q_pc[rd_ptr] : 32'h0;
  assign instr_pc_plus4 = instr_valid ? q_pc[rd_ptr] + 32'd4 : 32'h0;

endmodule
